fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch path: word sizes, PC stride and
// default parameter values used by fetch_unit and fetch_queue.
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;
  localparam int DEF_XLEN   = 32;
  localparam int DEF_QDEPTH = 2;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs between fetch and decode.
// A flush empties it at the next edge and overrides any push/pop that cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          push_data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          pop_data_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out unless count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (count_q == FULL)));

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= FULL);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential reads from fpc, keeps at most
// one read in flight, and buffers returned words for decode; branches redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC[XLEN-1:0],
  parameter int              QDEPTH   = DEF_QDEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_taken_i,
  input  logic [XLEN-1:0]    br_addr_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    out_pc_o,
  output logic [INSTR_W-1:0] out_instr_o
);

  localparam int CW = cnt_w(QDEPTH);
  localparam logic [CW:0]     QD_LIM     = (CW + 1)'(QDEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(PC_STEP - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]           q_count;
  logic [CW:0]             credit_used;
  logic [XLEN+INSTR_W-1:0] q_head;
  logic                    req, push, pop;

  // Credit uses start-of-cycle occupancy, so a pop frees space only next cycle.
  assign credit_used = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
  assign req         = !rst && !br_taken_i && (credit_used < QD_LIM);

  always_comb begin
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req;
    if (br_taken_i) begin
      fpc_d = br_addr_i & ALIGN_MASK;
    end else if (req) begin
      fpc_d    = fpc_q + STEP;
      req_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // A redirect drops the returning word and ignores decode's accept that cycle.
  assign push = inflight_q && !br_taken_i;
  assign pop  = out_valid_o && out_ready_i && !br_taken_i;

  fetch_queue #(
    .WIDTH (XLEN + INSTR_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (br_taken_i),
    .push_i      (push),
    .push_data_i ({req_pc_q, imem_rdata_i}),
    .pop_i       (pop),
    .pop_data_o  (q_head),
    .count_o     (q_count)
  );

  assign imem_req_o  = req;
  assign imem_addr_o = fpc_q;
  assign out_valid_o = (q_count != '0);
  assign out_pc_o    = q_head[XLEN+INSTR_W-1:INSTR_W];
  assign out_instr_o = q_head[INSTR_W-1:0];

  a_no_req_on_redirect: assert property (@(posedge clk) disable iff (rst)
    br_taken_i |-> !imem_req_o);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three configurations run side by side, each against a
// queue-based model of the fetch pipe plus directed literal checks.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int          QD  = (g == 1) ? 8 : 2;
    localparam logic [31:0] RPC = (g == 2) ? 32'hFFFF_FFF8 : 32'h0;

    logic        rst, br_taken, imem_req, out_valid, out_ready;
    logic [31:0] br_addr, imem_addr, imem_rdata, out_pc, out_instr;
    bit          done_g = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (
      .clk          (clk),
      .rst          (rst),
      .br_taken_i   (br_taken),
      .br_addr_i    (br_addr),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_rdata_i (imem_rdata),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_pc_o     (out_pc),
      .out_instr_o  (out_instr)
    );

    // Model: fetch pointer, one pending read, and a FIFO of {pc, word}.
    logic [31:0] m_fpc, m_pend_pc, m_pend_in;
    bit          m_inf;
    logic [31:0] mq_pc[$], mq_in[$];
    bit          mreq;
    logic [31:0] maddr;
    bit          scramble = 0;
    logic [31:0] req_log[$], pop_log[$];
    bit          l_valid, l_req;
    logic [31:0] l_pc, l_instr, l_addr;
    string       tag;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
      return scramble ? ({a[15:0], a[31:16]} ^ 32'h1357_9BDF) : a;
    endfunction

    task automatic model_reset();
      m_fpc = RPC;
      m_inf = 0;
      mq_pc.delete();
      mq_in.delete();
      mreq = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit bt, input logic [31:0] ba, input bit rdy);
      bit e_req, e_valid;
      br_taken = bt; br_addr = ba; out_ready = rdy;
      #1;
      e_req   = !bt && ((mq_pc.size() + int'(m_inf)) < QD);
      e_valid = (mq_pc.size() != 0);
      check({tag, "_imem_req"}, 32'(imem_req), 32'(e_req));
      check({tag, "_imem_addr"}, imem_addr, m_fpc);
      check({tag, "_out_valid"}, 32'(out_valid), 32'(e_valid));
      if (e_valid) begin
        check({tag, "_out_pc"}, out_pc, mq_pc[0]);
        check({tag, "_out_instr"}, out_instr, mq_in[0]);
      end
      l_valid = out_valid; l_req = imem_req; l_pc = out_pc; l_instr = out_instr; l_addr = imem_addr;
      if (imem_req) req_log.push_back(imem_addr);
      if (out_valid && rdy && !bt) pop_log.push_back(out_pc);
      mreq = imem_req; maddr = imem_addr;
      if (bt) begin
        m_fpc = {ba[31:2], 2'b00};
        mq_pc.delete(); mq_in.delete();
        m_inf = 0;
      end else begin
        if (e_valid && rdy) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (m_inf) begin
          mq_pc.push_back(m_pend_pc);
          mq_in.push_back(m_pend_in);
        end
        m_inf = e_req;
        if (e_req) begin
          m_pend_pc = m_fpc;
          m_pend_in = instr_of(m_fpc);
          m_fpc     = m_fpc + 32'd4;
        end
      end
      @(posedge clk); #1;
      imem_rdata = mreq ? instr_of(maddr) : $urandom();
      @(negedge clk);
    endtask

    task automatic pulse_rst(input int n);
      rst = 1'b1;
      #1;
      check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rst_req"}, 32'(imem_req), 32'd0);
      mreq = 0;
      repeat (n) begin
        @(posedge clk); #1;
        imem_rdata = $urandom();
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
    endtask

    initial begin
      bit          bt, rdy;
      logic [31:0] ba;
      tag = $sformatf("c%0d", g);
      rst = 1'b1; br_taken = 0; br_addr = '0; out_ready = 0; imem_rdata = '0;
      @(negedge clk);
      pulse_rst(2);

      // Straight-line fetch with identity memory (word == address).
      req_log.delete(); pop_log.delete();
      cycle(0, 0, 1);
      check({tag, "_first_req"}, 32'(l_req), 32'd1);
      check({tag, "_first_addr"}, l_addr, RPC);
      cycle(0, 0, 1);
      check({tag, "_second_addr"}, l_addr, RPC + 32'd4);
      cycle(0, 0, 1);
      check({tag, "_first_out_valid"}, 32'(l_valid), 32'd1);
      check({tag, "_first_out_pc"}, l_pc, RPC);
      check({tag, "_first_out_instr"}, l_instr, RPC);
      repeat (7) cycle(0, 0, 1);
      check({tag, "_req_log_len"}, 32'(req_log.size() >= 3), 32'd1);
      check({tag, "_pop_log_len"}, 32'(pop_log.size() >= 3), 32'd1);
      if (req_log.size() >= 3 && pop_log.size() >= 3) begin
        for (int k = 0; k < 3; k++) begin
          check({tag, "_seq_req"}, req_log[k], RPC + 32'(4 * k));
          check({tag, "_seq_pop"}, pop_log[k], RPC + 32'(4 * k));
        end
      end

      // Decode stall fills the queue and throttles requests.
      repeat (10) cycle(0, 0, 0);
      check({tag, "_stall_valid"}, 32'(l_valid), 32'd1);
      check({tag, "_stall_noreq"}, 32'(l_req), 32'd0);
      repeat (12) cycle(0, 0, 1);
      for (int k = 1; k < pop_log.size(); k++)
        check({tag, "_contig_pop"}, pop_log[k], pop_log[k-1] + 32'd4);

      // Redirect while full; 0x103 must align to 0x100.
      repeat (QD + 3) cycle(0, 0, 0);
      pop_log.delete();
      cycle(1, 32'h103, 1);
      cycle(0, 0, 1);
      check({tag, "_redir_t1_valid"}, 32'(l_valid), 32'd0);
      check({tag, "_redir_t1_addr"}, l_addr, 32'h100);
      cycle(0, 0, 1);
      check({tag, "_redir_t2_valid"}, 32'(l_valid), 32'd0);
      cycle(0, 0, 1);
      check({tag, "_redir_t3_valid"}, 32'(l_valid), 32'd1);
      check({tag, "_redir_t3_pc"}, l_pc, 32'h100);
      repeat (4) cycle(0, 0, 1);
      check({tag, "_redir_nonempty"}, 32'(pop_log.size() != 0), 32'd1);
      if (pop_log.size() != 0) check({tag, "_redir_first_pop"}, pop_log[0], 32'h100);

      // Reset with one entry queued and one read in flight.
      cycle(1, 32'h40, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      scramble = 1;
      pulse_rst(2);
      cycle(0, 0, 1);
      check({tag, "_post_rst_t1_valid"}, 32'(l_valid), 32'd0);
      cycle(0, 0, 1);
      check({tag, "_post_rst_t2_valid"}, 32'(l_valid), 32'd0);
      cycle(0, 0, 1);
      check({tag, "_post_rst_pc"}, l_pc, RPC);

      // Random decode back-pressure and redirects.
      repeat (600) begin
        bt  = ($urandom_range(0, 19) == 0);
        ba  = ($urandom_range(0, 3) == 0) ? 32'h203 : $urandom();
        rdy = ($urandom_range(0, 9) < 7);
        cycle(bt, ba, rdy);
      end
      done_g = 1;
    end
  end

  initial begin
    for (int i = 0; i < 30000; i++) begin
      if (cfg[0].done_g && cfg[1].done_g && cfg[2].done_g) break;
      @(posedge clk);
    end
    vectors++;
    if (!(cfg[0].done_g && cfg[1].done_g && cfg[2].done_g)) begin
      miscompares++;
      $display("FAIL timeout: configurations not finished, got %0d%0d%0d, expected 111",
               cfg[0].done_g, cfg[1].done_g, cfg[2].done_g);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
